// File: rtl/jsv_frame_status.sv
// jsv_frame_status
//   Avalon-MM input port for the Julia-set pixel engine status bits.
//   The CPU sees three things:
//     - the synchronised level of in_port;
//     - sticky per-bit edge captures;
//     - a level interrupt, raised when a captured bit is also set in the mask.
//   Software uses this to pace the next real/imag parameter write after a
//   frame completes.
//
//   Bus handshake: there is no waitrequest. An access is the single cycle in
//   which chipselect is high. write_n low in that cycle makes it a write,
//   write_n high makes it a read. Read data is registered and valid one
//   cycle after the chipselect cycle. readdata holds its value while
//   chipselect is low.
//
//   Register map (word addresses):
//     0  data          read:  synchronised in_port level; writes ignored
//     1  reserved      read:  0;                          writes ignored
//     2  irq mask      read/write
//     3  edge capture  read;  write-1-to-clear

module jsv_frame_status #(
  parameter int          WIDTH       = 32,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Depth is held to the legal 2..3 range, so a bad override cannot remove
  // the metastability guard.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 :
                          (SYNC_STAGES > 3) ? 3 : SYNC_STAGES;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture_clear;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_capture;
  logic [31:0]      rd_mux;

  assign sync_out = sync_q[STAGES-1];

  // Synchroniser chain: in_port is asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // One-cycle history of the synchronised level, used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync_out;
    end
  end

  // Edge pulse selection: 0 = rising, 1 = falling, anything else = both.
  always_comb begin
    edge_pulse = '0;
    case (EDGE_TYPE)
      0:       edge_pulse = sync_out & ~prev;
      1:       edge_pulse = ~sync_out & prev;
      default: edge_pulse = sync_out ^ prev;
    endcase
  end

  // Write decode, shared by the mask and capture registers.
  always_comb begin
    wr_en         = chipselect & ~write_n;
    wr_mask       = wr_en & (address == ADDR_MASK);
    wr_capture    = wr_en & (address == ADDR_CAPTURE);
    capture_clear = '0;
    if (wr_capture) begin
      capture_clear = writedata[WIDTH-1:0];
    end
  end

  // Sticky edge capture.
  // The set term is ORed in after the clear, so an edge arriving in the
  // same cycle as its clear is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture <= '0;
    end else begin
      capture <= (capture & ~capture_clear) | edge_pulse;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= RESET_MASK[WIDTH-1:0];
    end else if (wr_mask) begin
      mask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux, zero-extended to the bus width.
  // Capture is read as it stands before any clear in the same cycle.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_out;
      ADDR_RSVD:    rd_mux            = '0;
      ADDR_MASK:    rd_mux[WIDTH-1:0] = mask;
      ADDR_CAPTURE: rd_mux[WIDTH-1:0] = capture;
      default:      rd_mux            = '0;
    endcase
  end

  // Registered read data.
  // It updates on every selected cycle, including writes, and holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (chipselect) begin
      readdata <= rd_mux;
    end
  end

  // Level interrupt straight from flops.
  // It falls as soon as reset asserts, because capture clears asynchronously.
  assign irq = |(capture & mask);

endmodule
